// File: rtl/uart_reg_responder.sv
// uart_reg_responder: byte-oriented register access over a UART link.
// Frames are 'W' addr data (write) or 'R' addr (read). Every frame is answered
// with one byte: 'K' after a write, the register contents after a read, or
// 'E' for a bad command or out-of-range address. Each frame is abandoned
// silently on a framing error, on reset, or when the inter-byte timeout expires.
module uart_reg_responder #(
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       received,
  input  logic [7:0] rx_byte,
  input  logic       recv_error,
  input  logic       is_transmitting,
  output logic       transmit,
  output logic [7:0] tx_byte,
  output logic       wr_strobe,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       timeout
);

  localparam logic [7:0]  CMD_W       = 8'h57;
  localparam logic [7:0]  CMD_R       = 8'h52;
  localparam logic [7:0]  RSP_E       = 8'h45;
  localparam logic [7:0]  RSP_K       = 8'h4B;
  localparam logic [23:0] TIMEOUT_LIM = 24'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_SEND_WAIT,
    S_SEND_PULSE,
    S_SEND_GAP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_cmd_wr;
  logic [3:0]  r_addr;
  logic [23:0] r_idle_cnt;
  logic [7:0]  r_regs [16];

  logic        r_transmit;
  logic [7:0]  r_tx_byte;
  logic        r_wr_strobe;
  logic [3:0]  r_wr_addr;
  logic [7:0]  r_wr_data;
  logic        r_timeout;

  logic        w_tx_load;
  logic [7:0]  w_tx_byte_nxt;
  logic        w_transmit_set;
  logic        w_wr_en;
  logic        w_timeout_hit;
  logic        w_cmd_load;
  logic        w_addr_load;
  logic        w_cnt_clr;
  logic        w_idle_done;

  // The counter is cleared on entry, so the limit is hit on the cycle whose
  // increment would bring it to TIMEOUT_CYCLES.
  assign w_idle_done = ((r_idle_cnt + 24'd1) == TIMEOUT_LIM);

  assign transmit  = r_transmit;
  assign tx_byte   = r_tx_byte;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign timeout   = r_timeout;
  assign busy      = (r_state != S_IDLE);
  assign rd_data   = r_regs[rd_addr];

  // Next-state and per-cycle action decode; framing errors take priority over data.
  always_comb begin
    w_state_nxt    = r_state;
    w_tx_load      = 1'b0;
    w_tx_byte_nxt  = RSP_E;
    w_transmit_set = 1'b0;
    w_wr_en        = 1'b0;
    w_timeout_hit  = 1'b0;
    w_cmd_load     = 1'b0;
    w_addr_load    = 1'b0;
    w_cnt_clr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!recv_error && received) begin
          if (rx_byte == CMD_W || rx_byte == CMD_R) begin
            w_cmd_load  = 1'b1;
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_GET_ADDR;
          end else begin
            w_tx_load   = 1'b1;
            w_state_nxt = S_SEND_WAIT;
          end
        end
      end
      S_GET_ADDR: begin
        if (recv_error) begin
          w_state_nxt = S_IDLE;
        end else if (received) begin
          if (rx_byte[7:4] != 4'd0) begin
            w_tx_load   = 1'b1;
            w_state_nxt = S_SEND_WAIT;
          end else begin
            w_addr_load = 1'b1;
            if (r_cmd_wr) begin
              w_cnt_clr   = 1'b1;
              w_state_nxt = S_GET_DATA;
            end else begin
              w_tx_load     = 1'b1;
              w_tx_byte_nxt = r_regs[rx_byte[3:0]];
              w_state_nxt   = S_SEND_WAIT;
            end
          end
        end else if (w_idle_done) begin
          w_timeout_hit = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      S_GET_DATA: begin
        if (recv_error) begin
          w_state_nxt = S_IDLE;
        end else if (received) begin
          w_wr_en       = 1'b1;
          w_tx_load     = 1'b1;
          w_tx_byte_nxt = RSP_K;
          w_state_nxt   = S_SEND_WAIT;
        end else if (w_idle_done) begin
          w_timeout_hit = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      S_SEND_WAIT: begin
        if (!is_transmitting) begin
          w_transmit_set = 1'b1;
          w_state_nxt    = S_SEND_PULSE;
        end
      end
      S_SEND_PULSE: w_state_nxt = S_SEND_GAP;
      S_SEND_GAP:   w_state_nxt = S_IDLE;
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Inter-byte idle counter, running only while waiting for frame bytes.
  always_ff @(posedge clk) begin
    if (rst)
      r_idle_cnt <= 24'd0;
    else if (w_cnt_clr)
      r_idle_cnt <= 24'd0;
    else if (r_state == S_GET_ADDR || r_state == S_GET_DATA)
      r_idle_cnt <= r_idle_cnt + 24'd1;
  end

  // Frame context and registered UART / write-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_wr    <= 1'b0;
      r_addr      <= 4'd0;
      r_transmit  <= 1'b0;
      r_tx_byte   <= 8'h00;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 4'd0;
      r_wr_data   <= 8'h00;
      r_timeout   <= 1'b0;
    end else begin
      r_transmit  <= w_transmit_set;
      r_wr_strobe <= w_wr_en;
      r_timeout   <= w_timeout_hit;
      if (w_cmd_load)  r_cmd_wr  <= (rx_byte == CMD_W);
      if (w_addr_load) r_addr    <= rx_byte[3:0];
      if (w_tx_load)   r_tx_byte <= w_tx_byte_nxt;
      if (w_wr_en) begin
        r_wr_addr <= r_addr;
        r_wr_data <= rx_byte;
      end
    end
  end

  // Register file, written only by a completed write frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= 8'h00;
    end else if (w_wr_en) begin
      r_regs[r_addr] <= rx_byte;
    end
  end

endmodule

// File: doc/uart_reg_responder.md
UART_REG_RESPONDER -- requirements
Module: uart_reg_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 5000000: inter-byte timeout in clk cycles; legal range 2 to 2^24-1.
REQ-002 SHALL have port clk  input  1: clock; all logic is rising-edge.
REQ-003 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-004 SHALL have port received  input  1: one-cycle pulse from the UART when rx_byte is valid.
REQ-005 SHALL have port rx_byte  input  8: byte received from the UART.
REQ-006 SHALL have port recv_error  input  1: one-cycle pulse from the UART on a framing error.
REQ-007 SHALL have port is_transmitting  input  1: UART transmitter busy; low means it accepts transmit.
REQ-008 SHALL have port transmit  output  1: registered one-cycle request to the UART to send tx_byte.
REQ-009 SHALL have port tx_byte  output  8: registered response byte, held stable from transmit assertion until the next response.
REQ-010 SHALL have port wr_strobe  output  1: one-cycle pulse when a register is written.
REQ-011 SHALL have ports wr_addr  output  4 and wr_data  output  8: address and data of the last write.
REQ-012 SHALL have ports rd_addr  input  4 and rd_data  output  8: combinational host-side read of the register file.
REQ-013 SHALL have port busy  output  1: high in every state except IDLE.
REQ-014 SHALL have port timeout  output  1: one-cycle pulse when a frame is abandoned on timeout.

Function
REQ-015 SHALL hold a 16 x 8-bit register file, written only through the serial protocol.
REQ-016 SHALL implement states IDLE, GET_ADDR, GET_DATA, SEND_WAIT, SEND_PULSE, SEND_GAP.
REQ-017 IDLE + received: 0x57 ('W') or 0x52 ('R') -> latch command and go to GET_ADDR; any other byte -> tx_byte<=0x45 ('E') and go to SEND_WAIT.
REQ-018 GET_ADDR + received: if rx_byte[7:4]!=0 -> tx_byte<=0x45 and go to SEND_WAIT; else latch rx_byte[3:0]; 'W' -> GET_DATA; 'R' -> tx_byte<=reg[addr] and go to SEND_WAIT.
REQ-019 GET_DATA + received: on that edge reg[addr]<=rx_byte, wr_addr<=addr, wr_data<=rx_byte, wr_strobe<=1 for one cycle, tx_byte<=0x4B ('K'), then go to SEND_WAIT.
REQ-020 SEND_WAIT: stay while is_transmitting=1; when it is 0, transmit<=1 and go to SEND_PULSE.
REQ-021 SEND_PULSE: transmit<=0 and go to SEND_GAP; SEND_GAP: go to IDLE (this cycle covers the UART busy-flag latency).
REQ-022 Latency: final frame byte with received high in cycle N and the UART idle -> transmit high in cycle N+2 only.
REQ-023 received or recv_error arriving in SEND_WAIT, SEND_PULSE or SEND_GAP SHALL be ignored (byte dropped, no state change).
REQ-024 recv_error in IDLE, GET_ADDR or GET_DATA SHALL return to IDLE with no response and no write; recv_error wins if coincident with received.
REQ-025 A 24-bit idle counter SHALL clear on entry to GET_ADDR or GET_DATA and increment each cycle there; on reaching TIMEOUT_CYCLES -> go to IDLE, pulse timeout, no response and no write.
REQ-026 The write in REQ-019 SHALL be visible on rd_data in the cycle after the strobe edge; a read of the same address in the same frame sequence returns the new value.

Reset
REQ-027 rst SHALL force state IDLE, transmit=0, tx_byte=0x00, wr_strobe=0, wr_addr=0, wr_data=0, timeout=0, busy=0, idle counter=0, and all 16 registers=0x00.
REQ-028 rst asserted mid-frame or mid-response SHALL abandon it with no write and no further transmit pulse; a byte already handed to the UART is not recalled.

Verification
REQ-029 Bytes 0x57,0x03,0xA5 -> wr_strobe once with wr_addr=3, wr_data=0xA5; one transmit with tx_byte=0x4B two cycles after the third received; rd_addr=3 gives 0xA5.
REQ-030 Bytes 0x52,0x03 after REQ-029 -> one transmit, tx_byte=0xA5; 0x52,0x0F after reset -> tx_byte=0x00.
REQ-031 Byte 0x41 -> tx_byte=0x45; bytes 0x57,0x10 -> tx_byte=0x45, no wr_strobe.
REQ-032 is_transmitting held high 50 cycles when a response is due -> transmit stays 0 until the first cycle after it falls, then pulses exactly once.
REQ-033 TIMEOUT_CYCLES=20, bytes 0x57,0x02 then silence -> timeout pulse, busy falls, no transmit; recv_error in GET_DATA -> IDLE, no transmit.
REQ-034 rst in GET_DATA, then 0x52,0x02 -> tx_byte=0x00 and register 2 unchanged.
